// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic stream decoder: default sizing,
// derived window length and the decoder state encoding.
package sc_pkg;

  localparam int SNG_WIDTH_DEF  = 4;
  localparam int NUM_INPUTS_DEF = 2;

  // Number of valid beats in one decode window for a given SNG resolution.
  function automatic int sc_window_len(input int sng_width);
    return 1 << sng_width;
  endfunction

  localparam int WINDOW_LEN = sc_window_len(SNG_WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } sc_state_e;

endpackage

// File: rtl/sc_ones_counter.sv
// Single-channel ones accumulator. Wide enough that a full window of ones
// is representable exactly, so it never wraps within one window.
module sc_ones_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] count
);

  // Clear opens a window; otherwise add the stream bit on every qualified beat.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && bit_in)
      count <= count + W'(1);
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder. Counts ones on NUM_INPUTS channels over a
// window of 2^SNG_WIDTH valid beats and holds the counts behind a
// valid/ready handshake. Back-to-back windows are allowed when start
// coincides with the output handshake.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int SNG_WIDTH  = SNG_WIDTH_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                bit_valid,
  input  logic [NUM_INPUTS-1:0]               bit_in,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_INPUTS*(SNG_WIDTH+1)-1:0] count_out
);

  localparam int CW = SNG_WIDTH + 1;
  // Beat counter value at which the incoming beat is the window's last.
  localparam logic [CW-1:0] LAST_BEAT = CW'(sc_window_len(SNG_WIDTH) - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] beat_cnt;
  logic          beat, last_beat, accept, start_win;

  // Next-state logic and the per-cycle beat/handshake qualifiers.
  always_comb begin
    beat      = (state == S_ACCUM) && bit_valid;
    last_beat = beat && (beat_cnt == LAST_BEAT);
    accept    = (state == S_HOLD) && out_ready;
    start_win = ((state == S_IDLE) || accept) && start;
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (last_beat) state_nxt = S_HOLD;
      S_HOLD:  if (accept) state_nxt = start ? S_ACCUM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; busy/out_valid are flopped from the next state so the
  // outputs carry no combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == S_ACCUM);
      out_valid <= (state_nxt == S_HOLD);
    end
  end

  // Beat counter: cleared when a window opens, advanced on each valid beat.
  always_ff @(posedge clk) begin
    if (rst)
      beat_cnt <= '0;
    else if (start_win)
      beat_cnt <= '0;
    else if (beat)
      beat_cnt <= beat_cnt + CW'(1);
  end

  // One accumulator per channel, each driving its own slice of count_out.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    sc_ones_counter #(.W(CW)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_win),
      .en     (beat),
      .bit_in (bit_in[i]),
      .count  (count_out[i*CW +: CW])
    );
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Scoreboard bench for sc_stream_decoder: the driver computes each window's
// expected counts and out_valid cycle from the bit masks it will apply,
// the monitor compares them when the DUT presents a result.
module tb_sc_stream_decoder;

  localparam int W   = 4;
  localparam int N   = 2;
  localparam int CW  = W + 1;
  localparam int WIN = 1 << W;

  logic              clk = 1'b0;
  logic              rst, start, bit_valid, out_ready;
  logic [N-1:0]      bit_in;
  logic              busy, out_valid;
  logic [N*CW-1:0]   count_out;

  typedef struct {
    logic [N*CW-1:0] counts;
    int              rise_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   nvec = 0, nerr = 0;
  int   cyc  = 0;
  logic prev_ov = 1'b0;

  sc_stream_decoder #(.SNG_WIDTH(W), .NUM_INPUTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count_out (count_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on out_valid rise, then hold the counts steady until release.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov <= 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("counts", 32'(count_out), 32'(cur.counts));
          check("out_valid_cycle", cyc, cur.rise_cyc);
          check("busy_in_hold", 32'(busy), 32'd0);
        end
      end else if (out_valid && prev_ov) begin
        check("hold_stable", 32'(count_out), 32'(cur.counts));
      end
      prev_ov <= out_valid;
    end
  end

  // One window: m0/m1 give the per-beat bit of ch0/ch1. A gap of bit_valid=0
  // beats (with bit_in all ones) may be inserted before beat gap_at, and
  // start may be pulsed alongside beat start_at.
  task automatic run_window(input logic [WIN-1:0] m0, input logic [WIN-1:0] m1,
                            input int gap_at, input int gap_len, input int start_at);
    exp_t e;
    int   s;
    int   g;
    g = (gap_at >= 0 && gap_at < WIN) ? gap_len : 0;
    start = 1'b1;
    tick();
    s = cyc;
    start = 1'b0;
    out_ready = 1'b0;
    check("cleared_at_open", 32'(count_out), 32'd0);
    check("busy_at_open", 32'(busy), 32'd1);
    e.counts   = {CW'($countones(m1)), CW'($countones(m0))};
    e.rise_cyc = s + WIN + g;
    exp_q.push_back(e);
    for (int b = 0; b < WIN; b++) begin
      if (b == gap_at) begin
        repeat (gap_len) begin
          bit_valid = 1'b0;
          bit_in    = '1;
          start     = 1'b0;
          tick();
        end
      end
      bit_valid = 1'b1;
      bit_in    = {m1[b], m0[b]};
      start     = (b == start_at);
      tick();
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    bit_in    = N'($urandom);
  endtask

  // Hold backpressure for bp cycles with noise on the ignored inputs, then
  // complete the handshake; with b2b the next run_window opens in that cycle.
  task automatic release_hold(input int bp, input bit b2b);
    repeat (bp) begin
      out_ready = 1'b0;
      start     = 1'($urandom);
      bit_valid = 1'($urandom);
      bit_in    = N'($urandom);
      tick();
    end
    out_ready = 1'b1;
    start     = 1'b0;
    bit_valid = 1'($urandom);
    bit_in    = N'($urandom);
    if (!b2b) begin
      tick();
      out_ready = 1'b0;
      bit_valid = 1'b0;
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; out_ready = 1'b0; bit_in = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    rst = 1'b0;
    tick();

    // Full/empty channels.
    run_window(16'hFFFF, 16'h0000, -1, 0, -1);
    release_hold(0, 1'b0);

    // Alternating and sparse patterns with a 5-cycle gap mid-window.
    run_window(16'hAAAA, 16'h0421, 8, 5, -1);
    release_hold(2, 1'b0);

    // Long backpressure, then a back-to-back window decoding 5 and 11.
    run_window(16'($urandom), 16'($urandom), -1, 0, -1);
    release_hold(10, 1'b1);
    run_window(16'h001F, 16'h07FF, -1, 0, -1);
    release_hold(0, 1'b0);

    // Reset after 7 beats with start high in the same cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) begin
      bit_valid = 1'b1;
      bit_in    = '1;
      tick();
    end
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; bit_valid = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(count_out), 32'd0);
    tick();
    bit_valid = 1'b0;
    check("midrst_stays_idle", 32'(busy), 32'd0);
    run_window(16'h0F0F, 16'h8001, -1, 0, -1);
    release_hold(1, 1'b0);

    // start pulsed at beat 9 is ignored.
    run_window(16'h3C3C, 16'hFFFE, -1, 0, 9);
    release_hold(0, 1'b0);

    // Both channels saturated over a whole window.
    run_window(16'hFFFF, 16'hFFFF, 3, 2, -1);
    release_hold(3, 1'b0);

    // Randomised windows with random gaps, stray starts, backpressure and b2b.
    for (int k = 0; k < 20; k++) begin
      run_window(16'($urandom), 16'($urandom),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WIN-1)) : -1,
                 int'($urandom_range(1, 4)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, WIN-1)) : -1);
      release_hold(int'($urandom_range(0, 6)), (k != 19) && ($urandom_range(0, 1) == 1));
    end

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
